// File: rtl/alu_exec_datapath.sv
// Execute-stage datapath: operand-A 2:1 mux, operand-B 4:1 mux,
// 16-function combinational ALU and a registered result stage.
// res_comb_o is the unregistered result used for forwarding.
// res_o, zero_o and valid_o follow it by one clock.
module alu_exec_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic [3:0]       aluop_i,
    input  logic             a_sel_i,
    input  logic [1:0]       b_sel_i,
    input  logic [WIDTH-1:0] reg_a_i,
    input  logic [WIDTH-1:0] reg_b_i,
    input  logic [WIDTH-3:0] pc_i,
    input  logic [31:0]      ir_i,
    output logic [WIDTH-1:0] res_comb_o,
    output logic [WIDTH-1:0] res_o,
    output logic             zero_o,
    output logic             valid_o
);

    // Only the low log2(WIDTH) bits of B act as the shift amount.
    localparam int SH_W = $clog2(WIDTH);

    logic [WIDTH-1:0] imm16;
    logic [WIDTH-1:0] imm22;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [SH_W-1:0]  sh;
    logic             lt_signed;
    logic             lt_unsigned;
    logic             eq;
    logic [WIDTH-1:0] alu_res;

    // Immediates sign-extend from the instruction word; pc zero-extends.
    assign imm16 = {{(WIDTH-16){ir_i[15]}}, ir_i[15:0]};
    assign imm22 = {{(WIDTH-22){ir_i[21]}}, ir_i[21:0]};

    // Operand A: register value or the word-aligned program counter.
    always_comb begin
        op_a = reg_a_i;
        if (a_sel_i) begin
            op_a = {2'b00, pc_i};
        end
    end

    // Operand B: register, short immediate, long immediate or constant one.
    always_comb begin
        op_b = reg_b_i;
        case (b_sel_i)
            2'b00:   op_b = reg_b_i;
            2'b01:   op_b = imm16;
            2'b10:   op_b = imm22;
            default: op_b = {{(WIDTH-1){1'b0}}, 1'b1};
        endcase
    end

    assign sh          = op_b[SH_W-1:0];
    assign lt_signed   = $signed(op_a) < $signed(op_b);
    assign lt_unsigned = op_a < op_b;
    assign eq          = op_a == op_b;

    // ALU function select; every opcode is decoded so no X can escape.
    always_comb begin
        alu_res = '0;
        case (aluop_i)
            4'd0:    alu_res = op_a + op_b;
            4'd1:    alu_res = op_a - op_b;
            4'd2:    alu_res = op_a & op_b;
            4'd3:    alu_res = op_a | op_b;
            4'd4:    alu_res = op_a ^ op_b;
            4'd5:    alu_res = op_a << sh;
            4'd6:    alu_res = op_a >> sh;
            4'd7:    alu_res = $signed(op_a) >>> sh;
            4'd8:    alu_res = op_b;
            4'd9:    alu_res = ~op_b;
            4'd10:   alu_res = {{(WIDTH-1){1'b0}}, lt_signed};
            4'd11:   alu_res = {{(WIDTH-1){1'b0}}, lt_unsigned};
            4'd12:   alu_res = {{(WIDTH-1){1'b0}}, eq};
            4'd13:   alu_res = {{(WIDTH-1){1'b0}}, ~eq};
            4'd14:   alu_res = ~(op_a & op_b);
            default: alu_res = ~(op_a | op_b);
        endcase
    end

    assign res_comb_o = alu_res;

    // Result stage: reset clears, enable captures, otherwise stall and hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_o   <= '0;
            zero_o  <= 1'b1;
            valid_o <= 1'b0;
        end else if (en_i) begin
            res_o   <= alu_res;
            zero_o  <= (alu_res == '0);
            valid_o <= valid_i;
        end
    end

endmodule

// File: tb/tb_alu_exec_datapath.sv
// Testbench for alu_exec_datapath: directed and random vectors, expected
// results queued when driven and popped when the registered stage updates.
module tb_alu_exec_datapath;

    typedef struct {
        logic        a_sel;
        logic [1:0]  b_sel;
        logic [3:0]  op;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [29:0] pc;
        logic [31:0] ir;
        logic        valid;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_i;
    logic        valid_i;
    logic [3:0]  aluop_i;
    logic        a_sel_i;
    logic [1:0]  b_sel_i;
    logic [31:0] reg_a_i;
    logic [31:0] reg_b_i;
    logic [29:0] pc_i;
    logic [31:0] ir_i;
    logic [31:0] res_comb_o;
    logic [31:0] res_o;
    logic        zero_o;
    logic        valid_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Each entry: {valid, zero, result}
    logic [33:0] sb_q[$];

    alu_exec_datapath #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .en_i       (en_i),
        .valid_i    (valid_i),
        .aluop_i    (aluop_i),
        .a_sel_i    (a_sel_i),
        .b_sel_i    (b_sel_i),
        .reg_a_i    (reg_a_i),
        .reg_b_i    (reg_b_i),
        .pc_i       (pc_i),
        .ir_i       (ir_i),
        .res_comb_o (res_comb_o),
        .res_o      (res_o),
        .zero_o     (zero_o),
        .valid_o    (valid_o)
    );

    always #5 clk = ~clk;

    // Reference model written bit-serially for shifts, sign-bit split for slt.
    function automatic logic [31:0] model(input vec_t v);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        int          sh;
        a = v.a_sel ? {2'b00, v.pc} : v.ra;
        case (v.b_sel)
            2'b00:   b = v.rb;
            2'b01:   b = {{16{v.ir[15]}}, v.ir[15:0]};
            2'b10:   b = {{10{v.ir[21]}}, v.ir[21:0]};
            default: b = 32'd1;
        endcase
        sh = int'(b[4:0]);
        r  = a;
        case (v.op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  for (int i = 0; i < sh; i++) r = {r[30:0], 1'b0};
            4'd6:  for (int i = 0; i < sh; i++) r = {1'b0, r[31:1]};
            4'd7:  for (int i = 0; i < sh; i++) r = {r[31], r[31:1]};
            4'd8:  r = b;
            4'd9:  r = ~b;
            4'd10: r = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
            4'd11: r = {31'd0, a < b};
            4'd12: r = {31'd0, a == b};
            4'd13: r = {31'd0, a != b};
            4'd14: r = ~(a & b);
            default: r = ~(a | b);
        endcase
        return r;
    endfunction

    function automatic vec_t mk(input logic a_sel, input logic [1:0] b_sel,
                                input logic [3:0] op, input logic [31:0] ra,
                                input logic [31:0] rb, input logic [29:0] pc,
                                input logic [31:0] ir, input logic valid,
                                input logic [31:0] exp);
        vec_t v;
        v.a_sel = a_sel; v.b_sel = b_sel; v.op = op; v.ra = ra; v.rb = rb;
        v.pc = pc; v.ir = ir; v.valid = valid; v.exp = exp;
        return v;
    endfunction

    task automatic drive_inputs(input vec_t v);
        valid_i = v.valid;
        aluop_i = v.op;
        a_sel_i = v.a_sel;
        b_sel_i = v.b_sel;
        reg_a_i = v.ra;
        reg_b_i = v.rb;
        pc_i    = v.pc;
        ir_i    = v.ir;
    endtask

    // Drive one enabled cycle, queue its expected capture, return just after the edge.
    task automatic apply(input vec_t v);
        @(negedge clk);
        en_i = 1'b1;
        drive_inputs(v);
        sb_q.push_back({v.valid, (v.exp == 32'd0), v.exp});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        vec_t v;
        v = mk(1'b0, 2'b00, 4'd3, 32'hDEAD_BEEF, 32'h1234_5678, 30'h1555, 32'hFFFF_FFFF, 1'b1, 32'd0);
        @(negedge clk);
        rst  = 1'b1;
        en_i = 1'b1;
        drive_inputs(v);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (res_o !== 32'd0 || zero_o !== 1'b1 || valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: got res=%h zero=%b valid=%b, want res=00000000 zero=1 valid=0",
                     res_o, zero_o, valid_o);
        end else
            $display("reset: res=%h zero=%b valid=%b", res_o, zero_o, valid_o);
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
    endtask

    task automatic test_add_sub();
        vec_t        tbl[2];
        logic [33:0] e;
        tbl[0] = mk(1'b0, 2'b00, 4'd0, 32'hFFFF_FFFF, 32'd1, 30'd0, 32'd0, 1'b1, 32'h0000_0000);
        tbl[1] = mk(1'b0, 2'b00, 4'd1, 32'hFFFF_FFFF, 32'd1, 30'd0, 32'd0, 1'b1, 32'hFFFF_FFFE);
        foreach (tbl[i]) begin
            apply(tbl[i]);
            e = (sb_q.size() > 0) ? sb_q.pop_front() : 34'h3_FFFF_FFFF;
            n_checks++;
            if (res_comb_o !== tbl[i].exp) begin
                n_fail++;
                $display("FAIL add_sub comb[%0d]: got %h want %h", i, res_comb_o, tbl[i].exp);
            end
            n_checks++;
            if ({valid_o, zero_o, res_o} !== e) begin
                n_fail++;
                $display("FAIL add_sub reg[%0d]: got v=%b z=%b r=%h want v=%b z=%b r=%h",
                         i, valid_o, zero_o, res_o, e[33], e[32], e[31:0]);
            end else
                $display("add_sub op%0d: res=%h zero=%b", tbl[i].op, res_o, zero_o);
        end
    endtask

    task automatic test_pc_inc();
        vec_t        v;
        logic [33:0] e;
        v = mk(1'b1, 2'b11, 4'd0, 32'h0BAD_0BAD, 32'h5555_5555, 30'h3FFF_FFFF, 32'd0, 1'b1, 32'h4000_0000);
        apply(v);
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 34'h3_FFFF_FFFF;
        n_checks++;
        if ({valid_o, zero_o, res_o} !== e) begin
            n_fail++;
            $display("FAIL pc_inc: got v=%b z=%b r=%h want v=%b z=%b r=%h",
                     valid_o, zero_o, res_o, e[33], e[32], e[31:0]);
        end else
            $display("pc_inc: res=%h", res_o);
    endtask

    task automatic test_sign_ext();
        vec_t        tbl[3];
        logic [33:0] e;
        tbl[0] = mk(1'b0, 2'b01, 4'd8, 32'd0, 32'd0, 30'd0, 32'h0000_8000, 1'b1, 32'hFFFF_8000);
        tbl[1] = mk(1'b0, 2'b10, 4'd8, 32'd0, 32'd0, 30'd0, 32'hFFC0_1FFF | 32'h001F_E000, 1'b1, 32'h001F_FFFF);
        tbl[2] = mk(1'b0, 2'b10, 4'd8, 32'd0, 32'd0, 30'd0, 32'h0020_0001, 1'b0, 32'hFFE0_0001);
        foreach (tbl[i]) begin
            apply(tbl[i]);
            e = (sb_q.size() > 0) ? sb_q.pop_front() : 34'h3_FFFF_FFFF;
            n_checks++;
            if ({valid_o, zero_o, res_o} !== e) begin
                n_fail++;
                $display("FAIL sign_ext[%0d]: got v=%b z=%b r=%h want v=%b z=%b r=%h",
                         i, valid_o, zero_o, res_o, e[33], e[32], e[31:0]);
            end else
                $display("sign_ext b_sel=%0d: res=%h valid=%b", tbl[i].b_sel, res_o, valid_o);
        end
    endtask

    task automatic test_shift_cmp();
        vec_t        tbl[6];
        logic [33:0] e;
        tbl[0] = mk(1'b0, 2'b00, 4'd6,  32'h8000_0000, 32'd4,  30'd0, 32'd0, 1'b1, 32'h0800_0000);
        tbl[1] = mk(1'b0, 2'b00, 4'd7,  32'h8000_0000, 32'd4,  30'd0, 32'd0, 1'b1, 32'hF800_0000);
        tbl[2] = mk(1'b0, 2'b00, 4'd10, 32'h8000_0000, 32'd4,  30'd0, 32'd0, 1'b1, 32'd1);
        tbl[3] = mk(1'b0, 2'b00, 4'd11, 32'h8000_0000, 32'd4,  30'd0, 32'd0, 1'b1, 32'd0);
        tbl[4] = mk(1'b0, 2'b00, 4'd5,  32'h8000_0000, 32'd36, 30'd0, 32'd0, 1'b1, 32'd0);
        tbl[5] = mk(1'b0, 2'b00, 4'd5,  32'h0000_0003, 32'd36, 30'd0, 32'd0, 1'b1, 32'h0000_0030);
        foreach (tbl[i]) begin
            apply(tbl[i]);
            e = (sb_q.size() > 0) ? sb_q.pop_front() : 34'h3_FFFF_FFFF;
            n_checks++;
            if ({valid_o, zero_o, res_o} !== e) begin
                n_fail++;
                $display("FAIL shift_cmp[%0d] op%0d: got v=%b z=%b r=%h want v=%b z=%b r=%h",
                         i, tbl[i].op, valid_o, zero_o, res_o, e[33], e[32], e[31:0]);
            end else
                $display("shift_cmp op%0d: res=%h zero=%b", tbl[i].op, res_o, zero_o);
        end
    endtask

    task automatic test_stall();
        vec_t        v;
        logic [33:0] e;
        logic [31:0] t;
        v = mk(1'b0, 2'b00, 4'd8, 32'd0, 32'h0000_1234, 30'd0, 32'd0, 1'b1, 32'h0000_1234);
        apply(v);
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 34'h3_FFFF_FFFF;
        n_checks++;
        if ({valid_o, zero_o, res_o} !== e) begin
            n_fail++;
            $display("FAIL stall_load: got v=%b z=%b r=%h want v=%b z=%b r=%h",
                     valid_o, zero_o, res_o, e[33], e[32], e[31:0]);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            en_i    = 1'b0;
            t       = $urandom();
            v.ra    = t;
            v.rb    = t ^ 32'h5A5A_0000;
            v.op    = 4'(k);
            v.valid = k[0];
            drive_inputs(v);
            v.exp   = model(v);
            #1;
            n_checks++;
            if (res_comb_o !== v.exp) begin
                n_fail++;
                $display("FAIL stall_comb[%0d]: got %h want %h", k, res_comb_o, v.exp);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if ({valid_o, zero_o, res_o} !== e) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got v=%b z=%b r=%h want v=%b z=%b r=%h",
                         k, valid_o, zero_o, res_o, e[33], e[32], e[31:0]);
            end else
                $display("stall cycle %0d: res=%h comb=%h", k, res_o, res_comb_o);
        end
    endtask

    task automatic test_back_to_back();
        vec_t        v;
        logic [33:0] e;
        logic [31:0] t;
        for (int i = 0; i < 48; i++) begin
            v.a_sel = 1'($urandom_range(0, 1));
            v.b_sel = 2'($urandom_range(0, 3));
            v.op    = 4'(i % 16);
            v.ra    = $urandom();
            t       = $urandom();
            v.rb    = (i % 3 == 0) ? (t & 32'h0000_003F) : t;
            if (i % 5 == 0) v.rb = v.ra;
            t       = $urandom();
            v.pc    = t[29:0];
            v.ir    = $urandom();
            v.valid = 1'($urandom_range(0, 1));
            v.exp   = model(v);
            apply(v);
            e = (sb_q.size() > 0) ? sb_q.pop_front() : 34'h3_FFFF_FFFF;
            n_checks++;
            if (res_comb_o !== v.exp) begin
                n_fail++;
                $display("FAIL b2b_comb[%0d] op%0d: got %h want %h", i, v.op, res_comb_o, v.exp);
            end
            n_checks++;
            if ({valid_o, zero_o, res_o} !== e) begin
                n_fail++;
                $display("FAIL b2b_reg[%0d] op%0d: got v=%b z=%b r=%h want v=%b z=%b r=%h",
                         i, v.op, valid_o, zero_o, res_o, e[33], e[32], e[31:0]);
            end else
                $display("b2b %0d op%0d: res=%h valid=%b", i, v.op, res_o, valid_o);
        end
    endtask

    task automatic test_mid_reset();
        vec_t        v;
        logic [33:0] e;
        v = mk(1'b0, 2'b00, 4'd8, 32'd0, 32'h0000_ABCD, 30'd0, 32'd0, 1'b1, 32'h0000_ABCD);
        apply(v);
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 34'h3_FFFF_FFFF;
        n_checks++;
        if ({valid_o, zero_o, res_o} !== e) begin
            n_fail++;
            $display("FAIL mid_reset_load: got v=%b z=%b r=%h want v=%b z=%b r=%h",
                     valid_o, zero_o, res_o, e[33], e[32], e[31:0]);
        end
        @(negedge clk);
        rst  = 1'b1;
        en_i = 1'b1;
        v.rb = 32'h7777_0000;
        drive_inputs(v);
        @(posedge clk);
        #1;
        n_checks++;
        if (res_o !== 32'd0 || zero_o !== 1'b1 || valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got res=%h zero=%b valid=%b, want res=00000000 zero=1 valid=0",
                     res_o, zero_o, valid_o);
        end else
            $display("mid_reset: cleared");
        @(negedge clk);
        rst = 1'b0;
        v = mk(1'b0, 2'b00, 4'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 30'd0, 32'd0, 1'b1, 32'hFF00_FF00);
        apply(v);
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 34'h3_FFFF_FFFF;
        n_checks++;
        if ({valid_o, zero_o, res_o} !== e) begin
            n_fail++;
            $display("FAIL mid_reset_resume: got v=%b z=%b r=%h want v=%b z=%b r=%h",
                     valid_o, zero_o, res_o, e[33], e[32], e[31:0]);
        end else
            $display("mid_reset resume: res=%h", res_o);
    endtask

    initial begin
        rst     = 1'b1;
        en_i    = 1'b0;
        valid_i = 1'b0;
        aluop_i = 4'd0;
        a_sel_i = 1'b0;
        b_sel_i = 2'b00;
        reg_a_i = 32'd0;
        reg_b_i = 32'd0;
        pc_i    = 30'd0;
        ir_i    = 32'd0;
        test_reset();
        test_add_sub();
        test_pc_inc();
        test_sign_ext();
        test_shift_cmp();
        test_stall();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
